ram_arbiter: RTL and testbench

//  Shares the single-port byte-lane data RAM between two masters: M0 (CPU load/store port)
//  and M1 (loader/debug port).

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arb_grant.sv | 63 ++++++
 rtl/ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state encoding and RAM access-width codes for ram_arbiter.
`timescale 1ns/1ps
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] WIDTH_B = 2'd0;
    localparam logic [1:0] WIDTH_H = 2'd1;
    localparam logic [1:0] WIDTH_W = 2'd3;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arb_grant.sv
// ram_arb_grant: two-master winner select; fixed priority with starvation limit,
// or strict round-robin when RAM_ARB_RR_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module ram_arb_grant
    import ram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_arb_en,
    input  logic i_m0_req,
    input  logic i_m1_req,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef RAM_ARB_RR_EN
    logic r_last;

    // The master granted most recently yields when both are asking.
    always_comb begin
        o_gnt0 = i_arb_en & i_m0_req & (~i_m1_req | (r_last == OWNER_M1));
        o_gnt1 = i_arb_en & i_m1_req & ~o_gnt0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= OWNER_M1;
        end else if (o_gnt0 | o_gnt1) begin
            r_last <= o_gnt1;
        end
    end
`else
    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;
    logic       w_force;

    always_comb begin
        w_force = i_m1_req & (r_starve == c_limit);
        o_gnt1  = i_arb_en & i_m1_req & (~i_m0_req | w_force);
        o_gnt0  = i_arb_en & i_m0_req & ~o_gnt1;
    end

    // Counts M0 wins only while M1 is left waiting; cannot pass c_limit
    // because M1 takes the next grant once the limit is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve <= 4'd0;
        end else if (o_gnt1) begin
            r_starve <= 4'd0;
        end else if (o_gnt0) begin
            r_starve <= i_m1_req ? r_starve + 4'd1 : 4'd0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two masters onto a single-port byte-lane RAM (IDLE/ISSUE/WAIT/RESP).
// Build option: define RAM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
`timescale 1ns/1ps
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic [1:0]    m0_width,
    input  logic          m0_sign,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic [1:0]    m1_width,
    input  logic          m1_sign,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wea,
    output logic [1:0]    ram_width,
    output logic          ram_sign,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    input  logic          ram_err
);

    state_t        r_state;
    state_t        w_next;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          r_owner;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_width;
    logic          r_sign;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          w_resp;

    ram_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_arb_en (r_state == IDLE),
        .i_m0_req (m0_req),
        .i_m1_req (m1_req),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt0 | w_gnt1) w_next = ISSUE;
            ISSUE:   w_next = r_we ? RESP : WAIT;
            WAIT:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWNER_M0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_width <= 2'd0;
            r_sign  <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_gnt0 | w_gnt1) begin
                r_owner <= w_gnt1;
                r_addr  <= w_gnt1 ? m1_addr  : m0_addr;
                r_we    <= w_gnt1 ? m1_we    : m0_we;
                r_width <= w_gnt1 ? m1_width : m0_width;
                r_sign  <= w_gnt1 ? m1_sign  : m0_sign;
                r_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == ISSUE) begin
                r_err <= ram_err;
            end
            // RAM read data lands one cycle after the address was presented in ISSUE.
            if (r_state == WAIT) begin
                r_rdata <= ram_dout;
            end
        end
    end

    always_comb begin
        w_resp    = (r_state == RESP);
        m0_ready  = w_gnt0;
        m1_ready  = w_gnt1;
        m0_rvalid = w_resp & (r_owner == OWNER_M0);
        m1_rvalid = w_resp & (r_owner == OWNER_M1);
        m0_rdata  = m0_rvalid ? r_rdata : '0;
        m1_rdata  = m1_rvalid ? r_rdata : '0;
        m0_err    = m0_rvalid & r_err;
        m1_err    = m1_rvalid & r_err;
        ram_addr  = r_addr;
        ram_wea   = (r_state == ISSUE) & r_we;
        ram_width = r_width;
        ram_sign  = r_sign;
        ram_din   = r_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with scoreboard checking of ram_arbiter against a byte-lane RAM model.
`timescale 1ns/1ps
`default_nettype none

module tb_ram_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m0_sign, m0_ready, m0_rvalid, m0_err;
    logic [AW-1:0] m0_addr;
    logic [1:0]    m0_width;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_sign, m1_ready, m1_rvalid, m1_err;
    logic [AW-1:0] m1_addr;
    logic [1:0]    m1_width;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wea, ram_sign, ram_err;
    logic [1:0]    ram_width;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_width(m0_width),
        .m0_sign(m0_sign), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_width(m1_width),
        .m1_sign(m1_sign), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_wea(ram_wea), .ram_width(ram_width),
        .ram_sign(ram_sign), .ram_din(ram_din), .ram_dout(ram_dout), .ram_err(ram_err)
    );

    // RAM model: little-endian bytes, synchronous read, error on bad width or misalignment.
    logic [7:0] mem [0:255];

    assign ram_err = (ram_width == 2'd2) || ((ram_width & ram_addr[1:0]) != 2'd0);

    function automatic logic [31:0] ram_read(input logic [7:0] a, input logic [1:0] w, input logic s);
        logic [31:0] v;
        case (w)
            2'd0:    v = {{24{s & mem[a][7]}}, mem[a]};
            2'd1:    v = {{16{s & mem[8'(a + 8'd1)][7]}}, mem[8'(a + 8'd1)], mem[a]};
            default: v = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (ram_wea && !ram_err) begin
            mem[ram_addr[7:0]] = ram_din[7:0];
            if (ram_width != 2'd0) mem[8'(ram_addr[7:0] + 8'd1)] = ram_din[15:8];
            if (ram_width == 2'd3) begin
                mem[8'(ram_addr[7:0] + 8'd2)] = ram_din[23:16];
                mem[8'(ram_addr[7:0] + 8'd3)] = ram_din[31:24];
            end
        end
        ram_dout <= ram_err ? 32'd0 : ram_read(ram_addr[7:0], ram_width, ram_sign);
    end

    typedef struct {
        bit          m;
        logic [31:0] rdata;
        bit          err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   t6_win   = 1'b0;
    int   t6_wea_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Response monitor: pops the scoreboard whenever either master sees rvalid.
    always @(negedge clk) begin
        exp_t e;
        if (t6_win && ram_wea) t6_wea_cnt++;
        if (m0_rvalid || m1_rvalid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b, expected none", m0_rvalid, m1_rvalid);
            end else begin
                e = exp_q.pop_front();
                check("resp_onehot", {63'd0, m0_rvalid & m1_rvalid}, 64'd0);
                check("resp_owner", {63'd0, m1_rvalid}, {63'd0, e.m});
                check("resp_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                check("resp_err", {63'd0, e.m ? m1_err : m0_err}, {63'd0, e.err});
                check("resp_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input bit m, input bit we, input logic [31:0] addr, input logic [1:0] width,
                         input bit sign, input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        bit done = 1'b0;
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_width = width; m0_sign = sign; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_width = width; m1_sign = sign; m1_wdata = wdata;
        end
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (m ? m1_ready : m0_ready) begin
                done = 1'b1;
                exp_q.push_back('{m: m, rdata: (we ? 32'd0 : exp_rd), err: exp_err, due: cyc + (we ? 2 : 3)});
                grant_log.push_back(int'(m));
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: got no ready for m%0d, expected ready within 40 cycles", m);
        end
        @(posedge clk); #1;
        if (!m) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] order_act;
        logic [7:0] order_exp;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_width = 0; m0_sign = 0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_width = 0; m1_sign = 0; m1_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",      {62'd0, m0_ready, m1_ready}, 64'd0);
        check("rst_rvalid_err", {60'd0, m0_rvalid, m1_rvalid, m0_err, m1_err}, 64'd0);
        check("rst_rdata",      {m0_rdata, m1_rdata}, 64'd0);
        check("rst_ram_ctl",    {60'd0, ram_wea, ram_width, ram_sign}, 64'd0);
        check("rst_ram_bus",    {ram_addr, ram_din}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store/load round trip, then byte stores and signed/unsigned byte loads.
        issue(0, 1, 32'h10, 2'd3, 0, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 0, 32'h10, 2'd3, 0, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 1, 32'h13, 2'd0, 0, 32'h80, 32'h0, 0);
        issue(1, 0, 32'h13, 2'd0, 1, 32'h0, 32'hFFFFFF80, 0);
        issue(1, 0, 32'h13, 2'd0, 0, 32'h0, 32'h00000080, 0);
        // Misaligned half, then normal accesses unaffected.
        issue(0, 0, 32'h11, 2'd1, 0, 32'h0, 32'h0, 1);
        issue(0, 0, 32'h10, 2'd3, 0, 32'h0, 32'h80ADBEEF, 0);
        issue(0, 0, 32'h12, 2'd1, 1, 32'h0, 32'hFFFF80AD, 0);
        issue(1, 0, 32'h13, 2'd0, 0, 32'h0, 32'h00000080, 0);
        drain();

        // Both masters requesting back to back.
        grant_log.delete();
        fork
            for (int i = 0; i < 6; i++) issue(0, 1, 32'h40 + 32'(4 * i), 2'd3, 0, 32'(i), 32'h0, 0);
            for (int j = 0; j < 2; j++) issue(1, 1, 32'h80 + 32'(4 * j), 2'd3, 0, 32'(j), 32'h0, 0);
        join
        drain();
        check("order_count", grant_log.size(), 8);
        order_act = '0;
        for (int i = 0; i < 8 && i < grant_log.size(); i++) order_act[i] = grant_log[i][0];
`ifdef RAM_ARB_RR_EN
        order_exp = 8'b0000_1010;
`else
        order_exp = 8'b1001_0000;
`endif
        check("grant_order", {56'd0, order_act}, {56'd0, order_exp});

        // Reset asserted while a store is in ISSUE.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_width = 2'd3; m0_sign = 0; m0_wdata = 32'h12345678;
        @(negedge clk);
        check("t5_ready", {63'd0, m0_ready}, 64'd1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        check("t5_issue_wea", {63'd0, ram_wea}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5_wea_after_rst", {62'd0, ram_wea, m0_rvalid}, 64'd0);
        @(posedge clk); #1;
        check("t5_no_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 0, 32'h10, 2'd3, 0, 32'h0, 32'h80ADBEEF, 0);
        drain();

        // M1 raises and withdraws a store while the FSM is busy.
        grant_log.delete();
        t6_win = 1'b1;
        fork
            issue(0, 0, 32'h10, 2'd3, 0, 32'h0, 32'h80ADBEEF, 0);
            begin
                @(posedge clk); #1;
                m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_width = 2'd3; m1_wdata = 32'h0;
                @(negedge clk);
                check("t6_not_ready", {63'd0, m1_ready}, 64'd0);
                @(posedge clk); #1;
                m1_req = 1'b0;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        t6_win = 1'b0;
        check("t6_no_wea", t6_wea_cnt, 0);
        check("t6_grants", grant_log.size(), 1);
        issue(0, 0, 32'h10, 2'd3, 0, 32'h0, 32'h80ADBEEF, 0);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish before 200000ns");
        $fatal(1);
    end

endmodule

`default_nettype wire
